clk_div_sw: RTL and testbench
=============================

// Module: clk_div_sw
// PURPOSE
//  Parametrised, glitch-free clock generator/selector in a single clock domain.
//  Derives clk_out from clk using one of NUM_CH runtime-programmable divide ratios.
//  Switches between ratios, or starts and stops the output, only at period boundaries.
//  Sits in front of slow peripheral clock trees. Replaces two-clock mux switching
//  wherever all candidate clocks derive from one source.
// PARAMETERS
//  NUM_CH    4  number of selectable divide channels (2..2**SEL_W)
//  SEL_W     2  width of channel select
//  CNT_W     8  width of each divide ratio and of the period counter
//  PARK_CYC  4  extra low cycles inserted between old and new clock (CLK_SW_PARK_EN only)
//  RST_SEL   0  channel selected out of reset
// PORTS
//  clk         in   1            source clock
//  rst         in   1            async active-high reset
//  run_en      in   1            1 = generate clk_out; 0 = stop low after current period
//  sw_req      in   1            single-cycle switch request
//  sw_sel      in   SEL_W        requested channel, sampled with sw_req
//  div_cfg     in   NUM_CH*CNT_W ratio D of channel i at [i*CNT_W +: CNT_W]
//  clk_out     out  1            generated clock, registered (no combinational path)
//  cur_sel     out  SEL_W        channel currently driving clk_out
//  sw_busy     out  1            switch in progress (DRAIN/PARK)
//  sw_done     out  1            1-cycle pulse: switch complete, cur_sel updated
//  sw_drop     out  1            1-cycle pulse: request rejected
//  period_start out 1            1-cycle pulse coincident with each clk_out rising edge
// BEHAVIOUR
//  Reset (async, immediate): clk_out=0, cur_sel=RST_SEL, sw_busy/sw_done/sw_drop/period_start=0.
//    Reset also clears the counter and sets state IDLE. Reset mid-period truncates clk_out
//    low at once; this is the only permitted runt.
//  Ratio: De=max(D,2), latched at each period start. High phase H=ceil(De/2), low L=De-H.
//    div_cfg changes mid-period take effect at the next period start only.
//  States: IDLE, RUN, DRAIN, PARK.
//  IDLE: clk_out=0. When run_en=1, go to RUN; first high cycle of clk_out is the next cycle.
//  RUN: counter 0..De-1; clk_out=1 while counter<H; counter wraps to 0 at De-1.
//    Each wrap is a period boundary.
//  run_en=0 in RUN: complete current period (incl. full low phase), then IDLE.
//  sw_req in RUN, sw_sel!=cur_sel: sw_busy=1 next cycle; DRAIN until period boundary.
//    Then PARK (macro), then cur_sel<=sw_sel with sw_done=1 and sw_busy=0 in the same cycle.
//    Then RUN (first high next cycle), or IDLE if run_en=0.
//  sw_req in RUN/IDLE with sw_sel==cur_sel: sw_done pulse next cycle; no disruption.
//  sw_req in IDLE, new channel: cur_sel update and sw_done next cycle; no drain.
//  Rejected requests (sw_drop pulse next cycle, no state change):
//    sw_req while sw_busy=1, or sw_sel>=NUM_CH.
//  run_en toggling during DRAIN/PARK: the switch still completes; run_en is sampled at sw_done.
//  Glitch-free guarantee: every high phase is a full H of one channel.
//    Low time between old and new period >= L_old (+PARK_CYC).
//  Latency, RUN switch: sw_req -> sw_done = remaining cycles of old period + PARK_CYC + 1.
// CONFIGURATION
//  CLK_SW_PARK_EN defined: PARK state holds clk_out=0 for PARK_CYC cycles after DRAIN.
//    PARK_CYC=0 behaves as undefined.
//  CLK_SW_PARK_EN undefined: PARK state absent; DRAIN goes directly to the select update.
// TESTING
//  D0=4, run_en=1 after reset -> clk_out 1100 repeating; period_start every 4 cycles.
//  D0=5 -> high 3, low 2. D0=0 or 1 -> treated as 2 (10 pattern).
//  RUN ch0 D=8, sw_req sel=1 (D=2) at counter=2, PARK_CYC=4 with macro:
//    sw_done 10 cycles later; no high phase <4 before switch; then 10 pattern.
//    Without macro: sw_done 6 cycles later.
//  sw_req during sw_busy, and sw_sel=5 with NUM_CH=4 -> sw_drop pulses; cur_sel unchanged.
//  run_en drop mid-high (D=6) -> period finishes (3 high, 3 low), then clk_out stays 0.
//    run_en re-raise -> rise next cycle.
//  rst asserted mid-high / mid-DRAIN -> clk_out=0, cur_sel=RST_SEL, busy=0 immediately.
//    Restart is clean.

Source files
------------

// File: rtl/clk_div_sw.sv
// Glitch-free divided-clock generator with runtime channel selection.
// clk_out is derived from clk using one of NUM_CH divide ratios taken from div_cfg.
// Ratio changes, starts and stops take effect only at period boundaries.
// The select update happens in the cycle after the old period ends, so the low time
// between the old and new clock always exceeds the old channel's low phase.
// Optional feature macro: CLK_SW_PARK_EN adds PARK_CYC extra low cycles before the
// select update (PARK_CYC=0 makes the build behave as if the macro were undefined).
module clk_div_sw #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned PARK_CYC = 4,
    parameter int unsigned RST_SEL  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run_en,
    input  logic                    sw_req,
    input  logic [SEL_W-1:0]        sw_sel,
    input  logic [NUM_CH*CNT_W-1:0] div_cfg,
    output logic                    clk_out,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    sw_busy,
    output logic                    sw_done,
    output logic                    sw_drop,
    output logic                    period_start
);

    localparam int unsigned PW = (PARK_CYC > 1) ? $clog2(PARK_CYC) : 1;
`ifdef CLK_SW_PARK_EN
    localparam int unsigned PARK_LEN = PARK_CYC;
`else
    localparam int unsigned PARK_LEN = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_PARK  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  de_q;
    logic [CNT_W-1:0]  h_q;
    logic [SEL_W-1:0]  pend_sel;
    logic              drained;
    logic [PW-1:0]     pcnt;

    logic              req_ok_c;
    logic              req_new_c;
    logic              req_drop_c;
    logic [SEL_W-1:0]  launch_sel_c;
    logic [CNT_W-1:0]  raw_d_c;
    logic [CNT_W-1:0]  de_launch_c;
    logic [CNT_W-1:0]  h_launch_c;
    logic              boundary_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              high_nxt_c;
    logic              park_last_c;

    // Request qualification, ratio of the channel about to start, and counter helpers
    always_comb begin
        req_drop_c  = sw_req && (sw_busy || (32'(sw_sel) >= NUM_CH));
        req_ok_c    = sw_req && !req_drop_c;
        req_new_c   = req_ok_c && (sw_sel != cur_sel);

        launch_sel_c = cur_sel;
        if (state == ST_DRAIN || state == ST_PARK) begin
            launch_sel_c = pend_sel;
        end else if (req_ok_c) begin
            launch_sel_c = sw_sel;
        end

        raw_d_c     = div_cfg[int'(launch_sel_c) * int'(CNT_W) +: CNT_W];
        de_launch_c = (raw_d_c < CNT_W'(2)) ? CNT_W'(2) : raw_d_c;
        h_launch_c  = CNT_W'(({1'b0, de_launch_c} + (CNT_W+1)'(1)) >> 1);

        boundary_c  = (cnt == de_q - CNT_W'(1));
        cnt_inc_c   = cnt + CNT_W'(1);
        high_nxt_c  = (cnt_inc_c < h_q);
        park_last_c = ((32'(pcnt) + 32'd1) >= PARK_LEN);
    end

    // Period counter, switch sequencing and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            de_q         <= CNT_W'(2);
            h_q          <= CNT_W'(1);
            pend_sel     <= SEL_W'(RST_SEL);
            drained      <= 1'b0;
            pcnt         <= '0;
            clk_out      <= 1'b0;
            cur_sel      <= SEL_W'(RST_SEL);
            sw_busy      <= 1'b0;
            sw_done      <= 1'b0;
            sw_drop      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            sw_done      <= 1'b0;
            sw_drop      <= req_drop_c;
            period_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clk_out <= 1'b0;
                    if (req_ok_c) begin
                        cur_sel <= sw_sel;
                        sw_done <= 1'b1;
                    end
                    if (run_en) begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        de_q         <= de_launch_c;
                        h_q          <= h_launch_c;
                        clk_out      <= 1'b1;
                        period_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (req_new_c) begin
                        state    <= ST_DRAIN;
                        sw_busy  <= 1'b1;
                        pend_sel <= sw_sel;
                    end else if (req_ok_c) begin
                        sw_done <= 1'b1;
                    end
                    if (!boundary_c) begin
                        cnt     <= cnt_inc_c;
                        clk_out <= high_nxt_c;
                    end else if (req_new_c) begin
                        drained <= 1'b1;
                        clk_out <= 1'b0;
                    end else if (run_en) begin
                        cnt          <= '0;
                        de_q         <= de_launch_c;
                        h_q          <= h_launch_c;
                        clk_out      <= 1'b1;
                        period_start <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        clk_out <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        drained <= 1'b0;
                        if (PARK_LEN != 0) begin
                            state <= ST_PARK;
                            pcnt  <= '0;
                        end else begin
                            cur_sel <= pend_sel;
                            sw_done <= 1'b1;
                            sw_busy <= 1'b0;
                            if (run_en) begin
                                state        <= ST_RUN;
                                cnt          <= '0;
                                de_q         <= de_launch_c;
                                h_q          <= h_launch_c;
                                clk_out      <= 1'b1;
                                period_start <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else if (boundary_c) begin
                        drained <= 1'b1;
                        clk_out <= 1'b0;
                    end else begin
                        cnt     <= cnt_inc_c;
                        clk_out <= high_nxt_c;
                    end
                end
                ST_PARK: begin
                    clk_out <= 1'b0;
                    if (park_last_c) begin
                        cur_sel <= pend_sel;
                        sw_done <= 1'b1;
                        sw_busy <= 1'b0;
                        if (run_en) begin
                            state        <= ST_RUN;
                            cnt          <= '0;
                            de_q         <= de_launch_c;
                            h_q          <= h_launch_c;
                            clk_out      <= 1'b1;
                            period_start <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sw.sv
// Directed bench for clk_div_sw: ratio patterns, stop/restart, channel switching,
// rejected requests and asynchronous reset. Outputs are sampled 1 time unit after
// each rising edge of clk; inputs are driven at the same point.
module tb_clk_div_sw;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;
`ifdef CLK_SW_PARK_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 6;
`endif

    logic                    clk;
    logic                    rst;
    logic                    run_en;
    logic                    sw_req;
    logic [SEL_W-1:0]        sw_sel;
    logic [NUM_CH*CNT_W-1:0] div_cfg;
    logic                    clk_out;
    logic [SEL_W-1:0]        cur_sel;
    logic                    sw_busy;
    logic                    sw_done;
    logic                    sw_drop;
    logic                    period_start;

    int n_chk;
    int n_bad;

    clk_div_sw #(
        .NUM_CH  (NUM_CH),
        .SEL_W   (SEL_W),
        .CNT_W   (CNT_W),
        .PARK_CYC(4),
        .RST_SEL (0)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .sw_req      (sw_req),
        .sw_sel      (sw_sel),
        .div_cfg     (div_cfg),
        .clk_out     (clk_out),
        .cur_sel     (cur_sel),
        .sw_busy     (sw_busy),
        .sw_done     (sw_done),
        .sw_drop     (sw_drop),
        .period_start(period_start)
    );

    // Source clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Collect n consecutive samples of clk_out and period_start, first sample in the MSB
    task automatic grab(input int n, output logic [31:0] cv, output logic [31:0] pv);
        cv = '0;
        pv = '0;
        for (int i = 0; i < n; i++) begin
            step();
            cv = {cv[30:0], clk_out};
            pv = {pv[30:0], period_start};
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        run_en = 1'b0;
        sw_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        div_cfg = {d3, d2, d1, d0};
    endtask

    // Directed sequence
    initial begin
        logic [31:0] cv;
        logic [31:0] pv;
        logic        saw_high;
        int          k;

        n_chk   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        run_en  = 1'b0;
        sw_req  = 1'b0;
        sw_sel  = '0;
        set_cfg(8'd4, 8'd2, 8'd5, 8'd0);
        #2;

        // Reset state
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_sel", 32'(cur_sel), 32'd0);
        chk("rst_flags", {28'd0, sw_busy, sw_done, sw_drop, period_start}, 32'd0);
        step();
        rst = 1'b0;

        // D=4: 1100 repeating, period_start every 4 cycles
        run_en = 1'b1;
        grab(8, cv, pv);
        chk("d4_clk", cv, 32'b11001100);
        chk("d4_ps", pv, 32'b10001000);

        // D=5: high 3, low 2
        set_cfg(8'd5, 8'd2, 8'd5, 8'd0);
        do_reset();
        run_en = 1'b1;
        grab(10, cv, pv);
        chk("d5_clk", cv, 32'b1110011100);
        chk("d5_ps", pv, 32'b1000010000);

        // D=0 and D=1 behave as 2
        set_cfg(8'd0, 8'd2, 8'd5, 8'd0);
        do_reset();
        run_en = 1'b1;
        grab(6, cv, pv);
        chk("d0_clk", cv, 32'b101010);
        set_cfg(8'd1, 8'd2, 8'd5, 8'd0);
        do_reset();
        run_en = 1'b1;
        grab(4, cv, pv);
        chk("d1_clk", cv, 32'b1010);

        // D=6: run_en drops mid-high, period completes then output stays low
        set_cfg(8'd6, 8'd2, 8'd5, 8'd0);
        do_reset();
        run_en = 1'b1;
        grab(2, cv, pv);
        chk("stop_head", cv, 32'b11);
        run_en = 1'b0;
        grab(8, cv, pv);
        chk("stop_tail", cv, 32'b10000000);
        chk("stop_ps", pv, 32'd0);
        run_en = 1'b1;
        step();
        chk("restart_clk", 32'(clk_out), 32'd1);
        chk("restart_ps", 32'(period_start), 32'd1);

        // RUN switch ch0 (D=8) -> ch1 (D=2), request at counter=2
        set_cfg(8'd8, 8'd2, 8'd5, 8'd0);
        do_reset();
        run_en = 1'b1;
        step();
        step();
        step();
        sw_req = 1'b1;
        sw_sel = 3'd1;
        step();
        sw_req = 1'b0;
        chk("sw_busy_set", 32'(sw_busy), 32'd1);
        chk("sw_high_kept", 32'(clk_out), 32'd1);
        chk("sw_sel_hold", 32'(cur_sel), 32'd0);
        saw_high = 1'b0;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            k = i;
            if (sw_done) break;
            saw_high = saw_high | clk_out;
            if (i == 2) begin
                sw_req = 1'b1;
                sw_sel = 3'd2;
            end
            if (i == 3) begin
                sw_req = 1'b0;
                chk("busy_drop", 32'(sw_drop), 32'd1);
                chk("busy_drop_sel", 32'(cur_sel), 32'd0);
            end
        end
        chk("sw_latency", 32'(k), 32'(LAT));
        chk("sw_low_gap", 32'(saw_high), 32'd0);
        chk("sw_new_sel", 32'(cur_sel), 32'd1);
        chk("sw_busy_clr", 32'(sw_busy), 32'd0);
        chk("sw_first_high", {30'd0, clk_out, period_start}, 32'b11);
        grab(4, cv, pv);
        chk("sw_new_clk", cv, 32'b0101);
        chk("sw_new_ps", pv, 32'b0101);

        // Out-of-range select rejected
        sw_req = 1'b1;
        sw_sel = 3'd5;
        step();
        sw_req = 1'b0;
        chk("range_drop", {29'd0, sw_drop, sw_done, sw_busy}, 32'b100);
        chk("range_sel", 32'(cur_sel), 32'd1);

        // Same channel in RUN: done pulse, no disruption
        sw_req = 1'b1;
        sw_sel = 3'd1;
        step();
        sw_req = 1'b0;
        chk("same_done", {29'd0, sw_drop, sw_done, sw_busy}, 32'b010);

        // IDLE switch: immediate update
        do_reset();
        sw_req = 1'b1;
        sw_sel = 3'd3;
        step();
        sw_req = 1'b0;
        chk("idle_sel", 32'(cur_sel), 32'd3);
        chk("idle_done", {30'd0, sw_done, sw_busy}, 32'b10);
        chk("idle_clk", 32'(clk_out), 32'd0);

        // Async reset mid-DRAIN while clk_out is high, then clean restart
        do_reset();
        run_en = 1'b1;
        step();
        sw_req = 1'b1;
        sw_sel = 3'd2;
        step();
        sw_req = 1'b0;
        chk("pre_rst_state", {30'd0, clk_out, sw_busy}, 32'b11);
        rst = 1'b1;
        #1;
        chk("async_rst_clk", 32'(clk_out), 32'd0);
        chk("async_rst_sel", 32'(cur_sel), 32'd0);
        chk("async_rst_busy", 32'(sw_busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_start", {30'd0, clk_out, period_start}, 32'b11);
        chk("post_rst_sel", 32'(cur_sel), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
